// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared block type, feed state and counter increment (AES_CTR_FEED_INC128_EN selects 128-bit increment)
package aes_pkg;

   typedef logic [127:0] block_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } feed_state_t;

   function automatic block_t ctr_inc(input block_t c);
`ifdef AES_CTR_FEED_INC128_EN
      return c + 128'd1;
`else
      // inc32: only the low word counts, the nonce part is left alone
      return {c[127:32], c[31:0] + 32'd1};
`endif
   endfunction

endpackage

// File: rtl/aes_fifo.sv
// rtl/aes_fifo.sv - synchronous FIFO with count and empty flag; push and pop may coincide
module aes_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & ((count != FULL_COUNT) | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aes_ctr_feed.sv
// rtl/aes_ctr_feed.sv - CTR-mode flow-control wrapper around aes_encrypt (AES_CTR_FEED_INC128_EN: 128-bit counter)
module aes_ctr_feed
   import aes_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         load,
   output logic [127:0] pt,
   input  logic [127:0] ct,
   input  logic         valid,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         idle,
   output logic         err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);

   feed_state_t   state;
   block_t        ctr;
   logic [CW-1:0] credits;
   logic          err_q;
   logic          accept;
   logic          out_pop;
   logic          ret_push;
   logic          start_ok;
   block_t        pt_head;
   block_t        res_head;
   logic          pt_empty;
   logic          res_empty;
   logic [CW-1:0] pt_count;
   logic [CW-1:0] res_count;
   logic          unused_counts;

   // Credits cover both FIFOs, so the result FIFO can always absorb what the unstallable core returns
   assign idle      = (credits == FULL_CREDITS);
   assign in_ready  = (state == ST_ARMED) && (credits != '0) && !start;
   assign accept    = in_valid & in_ready;
   assign load      = accept;
   assign pt        = ctr;
   assign out_valid = ~res_empty;
   assign out_data  = res_head;
   assign out_pop   = out_valid & out_ready;
   assign ret_push  = valid & ~pt_empty;
   assign start_ok  = start & idle;
   assign err       = err_q;
   assign unused_counts = ^{pt_count, res_count};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ctr     <= '0;
         credits <= FULL_CREDITS;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:  if (start_ok) state <= ST_ARMED;
            ST_ARMED: state <= ST_ARMED;
         endcase

         if (start_ok) begin
            ctr <= iv;
         end else if (accept) begin
            ctr <= ctr_inc(ctr);
         end

         case ({accept, out_pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase

         if (valid & pt_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   aes_fifo #(
      .WIDTH (128),
      .DEPTH (DEPTH)
   ) u_pt_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (in_data),
      .pop       (ret_push),
      .head      (pt_head),
      .count     (pt_count),
      .empty     (pt_empty)
   );

   aes_fifo #(
      .WIDTH (128),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ret_push),
      .push_data (ct ^ pt_head),
      .pop       (out_pop),
      .head      (res_head),
      .count     (res_count),
      .empty     (res_empty)
   );

endmodule

// File: tb/tb_aes_ctr_feed.sv
// tb/tb_aes_ctr_feed.sv - directed bench for aes_ctr_feed with a fixed-latency stand-in core
`timescale 1ns/1ps
module tb_aes_ctr_feed;
   import aes_pkg::*;

   localparam int DEPTH = 16;
   localparam int L     = 3;

   logic   clk = 1'b0;
   logic   rst, start, in_valid, out_ready, inj;
   block_t iv, in_data, ct;
   logic   valid, in_ready, load, out_valid, idle, err;
   block_t pt, out_data;

   int     n_cmp = 0;
   int     n_bad = 0;

   logic   acc, ld, popd;
   block_t pts, ods, exp_pt, pop_exp, exp_ctr;
   block_t exp_q[$];

   always #5 clk = ~clk;

   aes_ctr_feed #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .iv(iv),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .load(load), .pt(pt), .ct(ct), .valid(valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .idle(idle), .err(err)
   );

   // Stand-in keystream: any fixed bijection of the counter exposes ordering and XOR errors
   function automatic block_t ks(input block_t c);
      return {c[63:0], c[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   function automatic block_t tb_inc(input block_t c);
      block_t r;
      r = c;
`ifdef AES_CTR_FEED_INC128_EN
      r = c + 128'd1;
`else
      r[31:0] = c[31:0] + 32'd1;
`endif
      return r;
   endfunction

   logic [L-1:0] pv;
   block_t       pp [L];
   always @(posedge clk) begin
      if (rst) pv <= '0;
      else     pv <= {pv[L-2:0], load};
      pp[0] <= pt;
      for (int i = 1; i < L; i++) pp[i] <= pp[i-1];
   end
   assign valid = pv[L-1] | inj;
   assign ct    = ks(pp[L-1]);

   task automatic cyc(input logic v, input block_t d, input logic ordy, input logic st);
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = ordy; start = st;
      #1;
      acc = in_valid & in_ready; ld = load; popd = out_valid & out_ready;
      pts = pt; ods = out_data;
      if (acc) begin
         exp_pt = exp_ctr;
         exp_q.push_back(ks(exp_ctr) ^ d);
         exp_ctr = tb_inc(exp_ctr);
      end
      if (popd) begin
         if (exp_q.size() != 0) pop_exp = exp_q.pop_front();
         else                   pop_exp = 'x;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inj = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      n_cmp++; if (load !== 1'b0)      begin n_bad++; $display("FAIL reset_load got=%b want=0", load); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
      n_cmp++; if (idle !== 1'b1)      begin n_bad++; $display("FAIL reset_idle got=%b want=1", idle); end
      cyc(1'b1, 128'h1, 1'b1, 1'b0);
      n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL unarmed_accept got=%b want=0", acc); end
   endtask

   task automatic test_kat();
      int first;
      iv = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
      cyc(1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 1'b1);
      n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL start_blocks_ready got=%b want=0", acc); end
      exp_ctr = iv;
      cyc(1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 1'b0);
      n_cmp++; if ({acc, ld} !== 2'b11) begin n_bad++; $display("FAIL kat_load got=%b want=11", {acc, ld}); end
      n_cmp++; if (pts !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff) begin n_bad++; $display("FAIL kat_pt0 got=%h want=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff", pts); end
      cyc(1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 1'b0);
      n_cmp++; if (pts !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) begin n_bad++; $display("FAIL kat_pt1 got=%h want=f0f1f2f3f4f5f6f7f8f9fafbfcfdff00", pts); end
      first = -1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (popd) begin
            if (first < 0) first = i;
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL kat_out got=%h want=%h", ods, pop_exp); end
         end
      end
      // first accept two cycles before the wait loop, output L+1 cycles later
      n_cmp++; if (first != 2) begin n_bad++; $display("FAIL kat_latency got=%0d want=2", first); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL kat_missing got=%0d want=0", exp_q.size()); end
      n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL kat_idle got=%b want=1", idle); end
   endtask

   task automatic test_wrap();
      block_t want;
`ifdef AES_CTR_FEED_INC128_EN
      want = 128'h00000000_00000000_00000002_00000000;
`else
      want = 128'h00000000_00000000_00000001_00000000;
`endif
      iv = 128'h00000000_00000000_00000001_ffffffff;
      cyc(1'b0, '0, 1'b1, 1'b1);
      exp_ctr = iv;
      cyc(1'b1, 128'h1111, 1'b1, 1'b0);
      n_cmp++; if (pts !== 128'h00000000_00000000_00000001_ffffffff) begin n_bad++; $display("FAIL wrap_pt0 got=%h want=1ffffffff", pts); end
      cyc(1'b1, 128'h2222, 1'b1, 1'b0);
      n_cmp++; if (pts !== want) begin n_bad++; $display("FAIL wrap_pt1 got=%h want=%h", pts, want); end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL wrap_out got=%h want=%h", ods, pop_exp); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_missing got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int n_acc, first;
      n_acc = 0;
      for (int i = 0; i < 24; i++) begin
         cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
         if (acc) n_acc++;
      end
      n_cmp++; if (n_acc != DEPTH) begin n_bad++; $display("FAIL bp_accepts got=%0d want=%0d", n_acc, DEPTH); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      first = -1;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
         if (i == 0) begin
            n_cmp++; if ({popd, acc} !== 2'b10) begin n_bad++; $display("FAIL bp_first_pop got=%b want=10", {popd, acc}); end
         end
         if (i == 1) begin
            n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL bp_resume got=%b want=1", acc); end
         end
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL bp_out got=%h want=%h", ods, pop_exp); end
         end
      end
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL bp_drain got=%h want=%h", ods, pop_exp); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_missing got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_start_busy();
      cyc(1'b1, 128'ha1, 1'b1, 1'b0);
      cyc(1'b1, 128'ha2, 1'b1, 1'b0);
      iv = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      cyc(1'b1, 128'ha3, 1'b1, 1'b1);
      n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL busy_start_ready got=%b want=0", acc); end
      cyc(1'b1, 128'ha3, 1'b1, 1'b0);
      n_cmp++; if (pts !== exp_pt) begin n_bad++; $display("FAIL busy_ctr got=%h want=%h", pts, exp_pt); end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL busy_out got=%h want=%h", ods, pop_exp); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL busy_missing got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_stream();
      int n_acc, gaps, bad_pt;
      n_acc = 0; gaps = 0; bad_pt = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
         if (acc) begin
            n_acc++;
            if (pts !== exp_pt) bad_pt++;
         end
         if (i >= L + 1 && !popd) gaps++;
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL stream_out got=%h want=%h", ods, pop_exp); end
         end
      end
      n_cmp++; if (n_acc != 200) begin n_bad++; $display("FAIL stream_accepts got=%0d want=200", n_acc); end
      n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
      n_cmp++; if (bad_pt != 0) begin n_bad++; $display("FAIL stream_ctr got=%0d want=0", bad_pt); end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (popd) begin
            n_cmp++; if (ods !== pop_exp) begin n_bad++; $display("FAIL stream_drain got=%h want=%h", ods, pop_exp); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_missing got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int stale;
      for (int i = 0; i < 5; i++) cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      do_reset();
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
      n_cmp++; if (idle !== 1'b1)      begin n_bad++; $display("FAIL rmid_idle got=%b want=1", idle); end
      n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL rmid_err got=%b want=0", err); end
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         if (out_valid || err) stale++;
      end
      n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rmid_stale got=%0d want=0", stale); end
   endtask

   task automatic test_err();
      @(negedge clk);
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err); end
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if ({err, out_valid} !== 2'b10) begin n_bad++; $display("FAIL err_sticky got=%b want=10", {err, out_valid}); end
      do_reset();
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b want=0", err); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inj = 1'b0;
      iv = '0; in_data = '0; exp_ctr = '0;
      test_reset();
      test_kat();
      test_wrap();
      test_backpressure();
      test_start_busy();
      test_stream();
      test_reset_mid();
      test_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aes_ctr_feed.md
# aes_ctr_feed

Counter-mode (CTR) front/back end for the pipelined `aes_encrypt` core. It accepts plaintext blocks on a valid/ready stream and issues one counter block per accepted block to the core's `load`/`pt` inputs. It XORs each returned keystream block (`ct`/`valid`) with the matching buffered plaintext and presents the result on a valid/ready output stream. It sits directly around `aes_encrypt`, supplying its inputs and consuming its outputs, so the fixed-latency, no-backpressure core becomes a flow-controlled CTR engine.

## Interface
- `DEPTH`, 16, credit/buffer depth in blocks; power of 2, ≥ 2; must be ≥ core latency + 2 for full throughput.
- `clk` input 1, the single clock.
- `rst` input 1, synchronous, active-high reset.
- `start` input 1, pulse; loads `iv` into the counter and arms the block.
- `iv` input 128, initial counter block (nonce || counter).
- `in_valid` input 1, plaintext block valid.
- `in_ready` output 1, plaintext block accepted when `in_valid & in_ready`.
- `in_data` input 128, plaintext block.
- `load` output 1, drives core `load`.
- `pt` output 128, drives core `pt`; carries the current counter.
- `ct` input 128, keystream from core.
- `valid` input 1, core output valid.
- `out_valid` output 1, result block valid.
- `out_ready` input 1, downstream accepts.
- `out_data` output 128, `in_data ^ keystream`.
- `idle` output 1, armed or not, nothing in flight or buffered.
- `err` output 1, sticky; core `valid` arrived with the plaintext buffer empty.

## Operation
- The block is a single clock domain, `clk`, with a synchronous active-high reset, `rst`.
- **Reset:**
  - `ctr` = 0, `armed` = 0, `credits` = `DEPTH`.
  - Both FIFOs are empty.
  - Outputs: `in_ready` = 0, `load` = 0, `out_valid` = 0, `err` = 0, `idle` = 1.
  - Integration drives core `rst_n = ~rst`, so the core pipeline is flushed together with this block.
- **States:**
  - IDLE (`armed` = 0) → ARMED on `start`.
  - ARMED stays ARMED. A new `start` is honoured only while `idle` = 1; otherwise it is ignored.
- **Start:** `ctr <= iv`, `armed <= 1`. `in_ready` is forced to 0 in any cycle where `start` = 1.
- **Accept:** `in_ready = armed & (credits != 0) & ~start`. On handshake:
  - `load` = 1 in the same cycle (combinational) and `pt = ctr`.
  - `in_data` is pushed into the plaintext FIFO.
  - `ctr` increments and `credits` decrements.
- **Increment:** `ctr[31:0] <= ctr[31:0] + 1` mod 2^32; `ctr[127:32]` is unchanged (inc32). See Configuration.
- **Return:** on core `valid`:
  - Pop the plaintext FIFO head.
  - Push `ct ^ head` into the result FIFO.
  - If the plaintext FIFO is empty, set `err` and push nothing.
- **Output:** `out_valid` = result FIFO non-empty; `out_data` = result FIFO head. On `out_valid & out_ready`, pop the entry and increment `credits`.
- **Credit invariant:** `credits` + plaintext count + result count = `DEPTH`. This guarantees the result FIFO never overflows, because the core cannot be stalled.
- **Simultaneous events:** accept and output handshake in the same cycle leave `credits` unchanged. A push and a pop on the same FIFO in the same cycle are both performed.
- `idle` = (`credits` == `DEPTH`).

## Timing
- `load`/`pt` are asserted in the acceptance cycle, so the core samples them at the same posedge.
- The result is registered: `out_valid` rises 1 cycle after core `valid`.
- Input-to-output latency = core latency L + 1 cycles.
- Sustained throughput is 1 block/cycle with `out_ready` held high and `DEPTH` ≥ L+2.
- With `out_ready` = 0, the block accepts exactly `DEPTH` blocks, then `in_ready` = 0.
- `in_ready` is reasserted the cycle after the first output pop.
- `err` is sticky until `rst`.

## Configuration
- `AES_CTR_FEED_INC128_EN`
  - Defined: `ctr` is a full 128-bit increment, mod 2^128.
  - Undefined: inc32, low word wraps and upper 96 bits are untouched.

## Structure
- The shared package `aes_pkg` holds:
  - `typedef logic [127:0] block_t`.
  - Function `ctr_inc(block_t)`, which is macro-selected.
- One sub-module, `aes_fifo #(WIDTH, DEPTH)`, is instantiated twice (plaintext and result). It provides synchronous push/pop, count, and an empty flag.
- The credit counter, `ctr` register and arming FSM live in `aes_ctr_feed`.

## Test plan
- **NIST SP800-38A F.5.1 known answer:**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `iv` f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff.
  - Plaintexts 6bc1bee22e409f96e93d7e117393172a and ae2d8a571e03ac9c9eb76fac45af8e51.
  - Required `out_data`: 874d6191b620e3261bef6864990db6ce, then 9806f66b7970fdff8617187bb9fffdff.
  - Required second `pt`: f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
- **Counter wrap:**
  - Stimulus: `iv` = 0x00…01_ffffffff, two blocks accepted.
  - Required second `pt`, macro undefined: 0x00…01_00000000.
  - Required second `pt`, macro defined: 0x00…02_00000000.
- **Backpressure:**
  - Stimulus: `DEPTH`=16, `out_ready`=0, `in_valid`=1 continuously.
  - Required: exactly 16 accepts, then `in_ready`=0.
  - Raise `out_ready`: 16 outputs in order, and the stream resumes.
- **Streaming throughput:**
  - Stimulus: 1000 random blocks, `out_ready`=1.
  - Required: one output per cycle after L+1 cycles; every output matches the DPI model `aes_encrypt_dpi(ctr) ^ pt`.
- **Start handling:**
  - Stimulus: `start` while blocks are outstanding.
  - Required: `ctr` unchanged, stream uncorrupted.
  - Stimulus: `start` together with `in_valid`.
  - Required: `in_ready`=0 that cycle.
- **Reset mid-stream:**
  - Stimulus: `rst` with 5 blocks in flight.
  - Required next cycle: `out_valid`=0, `idle`=1, `err`=0.
  - Required afterwards: no stale outputs.
